decode_stage: RTL and testbench

- Instruction-decode stage of the 5-stage RV32I pipeline, between the IF/ID and ID/EX pipeline registers.
- Decodes the 32-bit instruction into control signals, a sign-extended immediate and a destination register ID.
- Holds the 32x32 integer register file: two combinational read ports and one write-back port.
- Passes the PC and the branch-prediction information through to the next stage, and exposes every register for debug.

---
 rtl/decode_if.sv | 39 +++
 rtl/decode_stage.sv | 182 ++++++++++++++++++
 tb/tb_decode_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_if
// Description : Decode-stage bundle: IF/ID inputs, write-back port, decode
//               outputs and register-file debug view.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_if #(
  parameter int REGISTER_FILE_SIZE = 32,
  parameter int BP_W               = 33
);
  logic [31:0]                         instruction;
  logic [31:0]                         pc;
  logic                                write_en;
  logic [4:0]                          write_id;
  logic [31:0]                         write_data;
  logic [BP_W-1:0]                     branch_in;
  logic [BP_W-1:0]                     branch_out;
  logic [4:0]                          reg_rd_id;
  logic [31:0]                         pc_out;
  logic [31:0]                         read_data1;
  logic [31:0]                         read_data2;
  logic [31:0]                         immediate_data;
  logic [17:0]                         control_signals;
  logic [REGISTER_FILE_SIZE-1:0][31:0] debug_reg;

  modport master (
    output instruction, pc, write_en, write_id, write_data, branch_in,
    input  branch_out, reg_rd_id, pc_out, read_data1, read_data2,
           immediate_data, control_signals, debug_reg
  );

  modport slave (
    input  instruction, pc, write_en, write_id, write_data, branch_in,
    output branch_out, reg_rd_id, pc_out, read_data1, read_data2,
           immediate_data, control_signals, debug_reg
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I instruction decode with 32x32 register file and
//               same-cycle write-back bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int REGISTER_FILE_SIZE = 32,
  parameter int BP_W               = 33
) (
  input  wire logic clk,
  input  wire logic reset_n,
  decode_if.slave   bus
);
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_ialu   = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_sll  = 4'd2;
  localparam logic [3:0] c_alu_slt  = 4'd3;
  localparam logic [3:0] c_alu_sltu = 4'd4;
  localparam logic [3:0] c_alu_xor  = 4'd5;
  localparam logic [3:0] c_alu_srl  = 4'd6;
  localparam logic [3:0] c_alu_sra  = 4'd7;
  localparam logic [3:0] c_alu_or   = 4'd8;
  localparam logic [3:0] c_alu_and  = 4'd9;

  logic [REGISTER_FILE_SIZE-1:0][31:0] w_regs;
  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_wr_valid;

  assign w_ins      = bus.instruction;
  assign w_opcode   = w_ins[6:0];
  assign w_funct3   = w_ins[14:12];
  assign w_rs1      = w_ins[19:15];
  assign w_rs2      = w_ins[24:20];
  assign w_wr_valid = bus.write_en && (bus.write_id != 5'd0) && reset_n;

  // x0 is a constant; every other entry is a flop with async clear.
  genvar gi;
  generate
    for (gi = 0; gi < REGISTER_FILE_SIZE; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_regs[gi] = 32'd0;
      end else begin : g_live
        logic [31:0] r_q;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_q <= 32'd0;
          end else if (bus.write_en && bus.write_id == 5'(gi)) begin
            r_q <= bus.write_data;
          end
        end
        assign w_regs[gi] = r_q;
      end
    end
  endgenerate

  assign bus.read_data1 = (w_wr_valid && bus.write_id == w_rs1) ? bus.write_data : w_regs[w_rs1];
  assign bus.read_data2 = (w_wr_valid && bus.write_id == w_rs2) ? bus.write_data : w_regs[w_rs2];
  assign bus.debug_reg  = w_regs;
  assign bus.pc_out     = bus.pc;
  assign bus.branch_out = bus.branch_in;

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'd0};
  assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  // funct7[5] picks SUB only for register-register ops; SRA for both forms.
  logic [3:0] w_alu_f3;
  always_comb begin
    w_alu_f3 = c_alu_add;
    case (w_funct3)
      3'b000:  w_alu_f3 = (w_opcode == c_op_rtype && w_ins[30]) ? c_alu_sub : c_alu_add;
      3'b001:  w_alu_f3 = c_alu_sll;
      3'b010:  w_alu_f3 = c_alu_slt;
      3'b011:  w_alu_f3 = c_alu_sltu;
      3'b100:  w_alu_f3 = c_alu_xor;
      3'b101:  w_alu_f3 = w_ins[30] ? c_alu_sra : c_alu_srl;
      3'b110:  w_alu_f3 = c_alu_or;
      default: w_alu_f3 = c_alu_and;
    endcase
  end

  logic       w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src;
  logic       w_is_branch, w_is_jump, w_is_jalr, w_is_lui, w_is_auipc, w_illegal;
  logic [3:0] w_alu_op;
  logic [31:0] w_imm;

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_is_branch  = 1'b0;
    w_is_jump    = 1'b0;
    w_is_jalr    = 1'b0;
    w_is_lui     = 1'b0;
    w_is_auipc   = 1'b0;
    w_illegal    = 1'b0;
    w_alu_op     = c_alu_add;
    w_imm        = 32'd0;
    case (w_opcode)
      c_op_rtype: begin
        w_reg_write = 1'b1;
        w_alu_op    = w_alu_f3;
      end
      c_op_ialu: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = w_alu_f3;
        w_imm       = w_imm_i;
      end
      c_op_load: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_imm        = w_imm_i;
      end
      c_op_store: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_s;
      end
      c_op_branch: begin
        w_is_branch = 1'b1;
        w_alu_op    = c_alu_sub;
        w_imm       = w_imm_b;
      end
      c_op_jal: begin
        w_reg_write = 1'b1;
        w_is_jump   = 1'b1;
        w_imm       = w_imm_j;
      end
      c_op_jalr: begin
        w_reg_write = 1'b1;
        w_is_jump   = 1'b1;
        w_is_jalr   = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_i;
      end
      c_op_lui: begin
        w_reg_write = 1'b1;
        w_is_lui    = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_u;
      end
      c_op_auipc: begin
        w_reg_write = 1'b1;
        w_is_auipc  = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign bus.control_signals = {w_illegal, (w_illegal ? 3'd0 : w_funct3), w_alu_op,
                                w_is_auipc, w_is_lui, w_is_jalr, w_is_jump, w_is_branch,
                                w_alu_src, w_mem_to_reg, w_mem_write, w_mem_read, w_reg_write};
  assign bus.immediate_data  = w_imm;
  assign bus.reg_rd_id       = w_reg_write ? w_ins[11:7] : 5'd0;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed scoreboard bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  decode_if #(.REGISTER_FILE_SIZE(32), .BP_W(33)) bus ();
  decode_stage #(.REGISTER_FILE_SIZE(32), .BP_W(33)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [63:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", act);
      return;
    end
    e = sb.pop_front();
    assert (act === e.val) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, act, e.val);
    end
  endtask

  task automatic do_write(input logic [4:0] id, input logic [31:0] data);
    @(negedge clk);
    bus.write_en   = 1'b1;
    bus.write_id   = id;
    bus.write_data = data;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.instruction    = 32'd0;
    bus.pc             = 32'd0;
    bus.write_en       = 1'b0;
    bus.write_id       = 5'd0;
    bus.write_data     = 32'd0;
    bus.branch_in      = 33'd0;
    #1;
    expect_v("reset_regs_zero", 64'd0); check_v({63'd0, |bus.debug_reg});

    @(negedge clk);
    reset_n = 1'b1;
    do_write(5'd5, 32'h12345678);
    bus.instruction = 32'h00028033;  // add x0,x5,x0
    #1;
    expect_v("x5_written", 64'h12345678); check_v({32'd0, bus.debug_reg[5]});
    expect_v("x5_read",    64'h12345678); check_v({32'd0, bus.read_data1});

    // Async reset mid-cycle, with a write pending that must be dropped.
    @(negedge clk);
    #1;
    bus.write_en   = 1'b1;
    bus.write_id   = 5'd6;
    bus.write_data = 32'hCAFEF00D;
    reset_n        = 1'b0;
    #1;
    expect_v("async_reset_regs", 64'd0); check_v({63'd0, |bus.debug_reg});
    expect_v("async_reset_rd1",  64'd0); check_v({32'd0, bus.read_data1});
    @(posedge clk);
    #1;
    expect_v("reset_write_dropped", 64'd0); check_v({32'd0, bus.debug_reg[6]});
    bus.write_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    do_write(5'd2, 32'hDEADBEEF);
    bus.instruction = 32'h00010033;  // add x0,x2,x0
    #1;
    expect_v("add_rd1",  64'hDEADBEEF); check_v({32'd0, bus.read_data1});
    expect_v("add_rd2",  64'd0);        check_v({32'd0, bus.read_data2});
    expect_v("add_rdid", 64'd0);        check_v({59'd0, bus.reg_rd_id});
    expect_v("add_ctrl", 64'h00001);    check_v({46'd0, bus.control_signals});
    expect_v("add_imm",  64'd0);        check_v({32'd0, bus.immediate_data});

    do_write(5'd0, 32'hFFFFFFFF);
    expect_v("x0_protected", 64'd0); check_v({32'd0, bus.debug_reg[0]});

    // Bypass on x0 must not happen.
    @(negedge clk);
    bus.write_en    = 1'b1;
    bus.write_id    = 5'd0;
    bus.write_data  = 32'hFFFFFFFF;
    bus.instruction = 32'h00000033;
    #1;
    expect_v("x0_no_bypass", 64'd0); check_v({32'd0, bus.read_data1});
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;

    // Same-cycle bypass x3.
    @(negedge clk);
    bus.write_en    = 1'b1;
    bus.write_id    = 5'd3;
    bus.write_data  = 32'h00000055;
    bus.instruction = 32'h00018033;  // add x0,x3,x0
    #1;
    expect_v("bypass_rd1",      64'h55); check_v({32'd0, bus.read_data1});
    expect_v("bypass_pre_edge", 64'd0);  check_v({32'd0, bus.debug_reg[3]});
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    expect_v("x3_written", 64'h55); check_v({32'd0, bus.debug_reg[3]});

    bus.instruction = 32'h00500093;  // addi x1,x0,5
    #1;
    expect_v("addi_imm",  64'd5);     check_v({32'd0, bus.immediate_data});
    expect_v("addi_rdid", 64'd1);     check_v({59'd0, bus.reg_rd_id});
    expect_v("addi_ctrl", 64'h00011); check_v({46'd0, bus.control_signals});

    bus.instruction = 32'hFE000CE3;  // beq x0,x0,-8
    #1;
    expect_v("beq_imm",  64'hFFFFFFF8); check_v({32'd0, bus.immediate_data});
    expect_v("beq_rdid", 64'd0);        check_v({59'd0, bus.reg_rd_id});
    expect_v("beq_ctrl", 64'h00420);    check_v({46'd0, bus.control_signals});

    bus.instruction = 32'h00812203;  // lw x4,8(x2)
    #1;
    expect_v("lw_imm",  64'd8);          check_v({32'd0, bus.immediate_data});
    expect_v("lw_rdid", 64'd4);          check_v({59'd0, bus.reg_rd_id});
    expect_v("lw_ctrl", 64'h0801B);      check_v({46'd0, bus.control_signals});
    expect_v("lw_rd1",  64'hDEADBEEF);   check_v({32'd0, bus.read_data1});

    bus.instruction = 32'h40310333;  // sub x6,x2,x3
    #1;
    expect_v("sub_ctrl", 64'h00401); check_v({46'd0, bus.control_signals});
    expect_v("sub_rd2",  64'h55);    check_v({32'd0, bus.read_data2});
    expect_v("sub_rdid", 64'd6);     check_v({59'd0, bus.reg_rd_id});

    bus.instruction = 32'h4030D393;  // srai x7,x1,3
    #1;
    expect_v("srai_ctrl", 64'h15C11); check_v({46'd0, bus.control_signals});
    expect_v("srai_imm",  64'h403);   check_v({32'd0, bus.immediate_data});

    bus.instruction = 32'h010000EF;  // jal x1,16
    #1;
    expect_v("jal_ctrl", 64'h00041); check_v({46'd0, bus.control_signals});
    expect_v("jal_imm",  64'd16);    check_v({32'd0, bus.immediate_data});

    bus.pc          = 32'h00000100;
    bus.branch_in   = {1'b1, 32'h00000200};
    bus.instruction = 32'hFFFFFFFF;
    #1;
    expect_v("pc_out",       64'h100);       check_v({32'd0, bus.pc_out});
    expect_v("branch_out",   64'h1_00000200); check_v({31'd0, bus.branch_out});
    expect_v("illegal_ctrl", 64'h20000);     check_v({46'd0, bus.control_signals});
    expect_v("illegal_imm",  64'd0);         check_v({32'd0, bus.immediate_data});
    expect_v("illegal_rdid", 64'd0);         check_v({59'd0, bus.reg_rd_id});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
